icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
// - Direct-mapped instruction cache: the cache-side responder for the datapath's instruction port.
// - Answers imemREN/imemaddr with ihit/imemload in the same cycle on a hit.
// - On a miss, fetches the word from the memory controller over iREN/iaddr/iwait/iload.
// - Sits between the pipelined datapath (IF stage) and the memory controller.
// PARAMETERS
// - SETS     16  number of one-word frames; power of 2; IDX_W = $clog2(SETS)
// - TAG_W    30-IDX_W  tag width (derived localparam, not overridable)
// PORTS
// - CLK       in   1   clock, rising edge
// - nRST      in   1   asynchronous active-low reset
// - imemREN   in   1   datapath instruction read request
// - imemaddr  in   32  byte address; bits [1:0] ignored
// - ihit      out  1   imemload valid this cycle for imemaddr
// - imemload  out  32  instruction word
// - iREN      out  1   memory-controller read request
// - iaddr     out  32  memory-controller address, word aligned
// - iwait     in   1   memory busy; iload valid in a cycle with iREN=1, iwait=0
// - iload     in   32  memory read data
// BEHAVIOUR
// - Address split: idx = imemaddr[IDX_W+1:2], tag = imemaddr[31:IDX_W+2].
// - Storage: per-frame valid bit (reset to 0), tag, data. No writes from the datapath.
// - Reset, asynchronous: all valid=0, state=IDLE, miss_addr=0.
//   Outputs while in reset: ihit=0, iREN=0, iaddr=0, imemload=0.
// - FSM state IDLE:
//   - ihit = imemREN & valid[idx] & tag match, combinational, zero latency.
//   - imemload = data[idx] when ihit; 0 otherwise.
//   - imemREN & !hit: latch miss_addr = {imemaddr[31:2],2'b00}, go to FETCH.
// - FSM state FETCH:
//   - iREN=1, iaddr=miss_addr, ihit=0 (except under ICACHE_FILL_FWD_EN).
//   - iwait=0: write frame[miss_addr idx] with valid=1, tag and data=iload, then go to IDLE.
//   - iwait=1: stay in FETCH, holding iREN and iaddr stable.
// - Base miss latency: N+1 cycles, where N = cycles iREN is held until iwait=0.
//   The hit appears in IDLE on the cycle after the fill.
// - imemaddr changes during FETCH (redirect): fill still completes to miss_addr.
//   IDLE then re-checks the new address, which may miss again.
// - imemREN drops during FETCH (halt): fill still completes; no new request issued.
// - Conflict: a new miss to the same idx overwrites the frame; no replacement state.
// - Reset asserted mid-FETCH: iREN drops immediately; the partial fill is discarded.
// - iREN is never asserted in IDLE; iaddr=0 in IDLE.
// - imemREN=0 in IDLE: ihit=0, no state change.
// CONFIGURATION
// - ICACHE_FILL_FWD_EN defined:
//   - In the FETCH cycle with iwait=0, also drive ihit=1 and imemload=iload,
//     provided imemREN=1 and imemaddr[31:2] == miss_addr[31:2].
//   - Miss latency becomes N cycles. The frame write is unchanged.
// - ICACHE_FILL_FWD_EN undefined:
//   - ihit=0 for the whole of FETCH; the hit comes the cycle after the fill.
// TESTING
// - Reset, imemREN=1, imemaddr=0x0 -> ihit=0, iREN=1, iaddr=0x0.
//   Memory iwait=1 for 3 cycles, then iload=0x2008000A.
//   Next cycle: ihit=1, imemload=0x2008000A (FWD_EN: ihit=1 in the fill cycle).
// - After the fill, read 0x0 again -> ihit=1 in the same cycle, iREN stays 0.
// - Fill 0x4, then read 0x44 (same idx, SETS=16) -> miss, iaddr=0x44.
//   After the fill, a read of 0x4 misses again.
// - Miss on 0x10; imemaddr switches to 0x80 during FETCH.
//   -> Fill writes 0x10; IDLE then misses on 0x80 with iaddr=0x80.
//   -> A later read of 0x10 hits.
// - Pulse nRST low mid-FETCH -> iREN=0 at once; all frames invalid.
//   The previously cached 0x0 misses after reset.
// - imemREN=0 with a valid address -> ihit=0, iREN=0 for 10 cycles, no state change.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache, one-word frames, blocking miss fill.
// Optional ICACHE_FILL_FWD_EN forwards iload to the datapath in the fill cycle.
module icache #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t state, next_state;

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags [SETS];
   logic [31:0]      data [SETS];
   logic [31:0]      miss_addr;

   logic [IDX_W-1:0] idx, midx;
   logic [TAG_W-1:0] tag, mtag;
   logic             hit;
   logic             fill;

   assign idx  = imemaddr[IDX_W+1:2];
   assign tag  = imemaddr[31:IDX_W+2];
   assign midx = miss_addr[IDX_W+1:2];
   assign mtag = miss_addr[31:IDX_W+2];
   assign hit  = imemREN & valid[idx] & (tags[idx] == tag);
   assign fill = (state == FETCH) & ~iwait;

   // State and latched miss address; reset drops any fetch in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         miss_addr <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && imemREN && !hit)
            miss_addr <= {imemaddr[31:2], 2'b00};
      end
   end

   // Frame storage: written only when the memory returns the miss word.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
         for (int i = 0; i < SETS; i++) begin
            tags[i] <= '0;
            data[i] <= '0;
         end
      end else if (fill) begin
         valid[midx] <= 1'b1;
         tags[midx]  <= mtag;
         data[midx]  <= iload;
      end
   end

   // Next state and all outputs; hit path is purely combinational.
   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      imemload   = '0;
      iREN       = 1'b0;
      iaddr      = '0;
      unique case (state)
         IDLE: begin
            ihit = hit;
            if (hit)
               imemload = data[idx];
            if (imemREN && !hit)
               next_state = FETCH;
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = miss_addr;
`ifdef ICACHE_FILL_FWD_EN
            if (!iwait && imemREN &&
                imemaddr[31:2] == miss_addr[31:2]) begin
               ihit     = 1'b1;
               imemload = iload;
            end
`endif
            if (!iwait)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Expectations follow ICACHE_FILL_FWD_EN when defined.
module tb_icache;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   int passed = 0;
   int total  = 0;

`ifdef ICACHE_FILL_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   icache dut (
      .CLK(CLK), .nRST(nRST),
      .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload),
      .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", name, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Return a word from memory in this FETCH cycle.
   task automatic fill(input logic [31:0] w);
      iwait = 1'b0;
      iload = w;
      tick();
      iwait = 1'b1;
      iload = '0;
      #1;
   endtask

   initial begin
      nRST = 1'b0; imemREN = 1'b0; imemaddr = '0;
      iwait = 1'b1; iload = '0;
      #3;
      chk("rst_ihit", {31'b0, ihit}, 32'd0);
      chk("rst_iREN", {31'b0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_load", imemload, 32'd0);
      tick(); tick();
      nRST = 1'b1;

      // cold miss on 0x0, memory busy 3 cycles
      imemREN = 1'b1; imemaddr = 32'h0; #1;
      chk("cold_ihit", {31'b0, ihit}, 32'd0);
      chk("cold_idle_iREN", {31'b0, iREN}, 32'd0);
      tick();
      chk("f0_iREN", {31'b0, iREN}, 32'd1);
      chk("f0_iaddr", iaddr, 32'h0);
      chk("f0_ihit", {31'b0, ihit}, 32'd0);
      tick(); tick();
      chk("f0_wait_iREN", {31'b0, iREN}, 32'd1);
      iwait = 1'b0; iload = 32'h2008000A; #1;
      chk("f0_fill_ihit", {31'b0, ihit}, {31'b0, FWD});
      chk("f0_fill_load", imemload, FWD ? 32'h2008000A : 32'h0);
      tick();
      iwait = 1'b1; iload = '0; #1;
      chk("h0_ihit", {31'b0, ihit}, 32'd1);
      chk("h0_load", imemload, 32'h2008000A);
      chk("h0_iREN", {31'b0, iREN}, 32'd0);
      tick();
      imemaddr = 32'h3; #1;
      chk("h3_ihit", {31'b0, ihit}, 32'd1);
      chk("h3_load", imemload, 32'h2008000A);

      // conflict: 0x4 and 0x44 share idx 1
      imemaddr = 32'h4; #1;
      chk("m4_ihit", {31'b0, ihit}, 32'd0);
      tick();
      chk("m4_iaddr", iaddr, 32'h4);
      fill(32'h11111111);
      chk("h4_load", imemload, 32'h11111111);
      imemaddr = 32'h44; #1;
      chk("m44_ihit", {31'b0, ihit}, 32'd0);
      tick();
      chk("m44_iaddr", iaddr, 32'h44);
      fill(32'h44444444);
      chk("h44_ihit", {31'b0, ihit}, 32'd1);
      chk("h44_load", imemload, 32'h44444444);
      imemaddr = 32'h4; #1;
      chk("re4_ihit", {31'b0, ihit}, 32'd0);
      tick();
      chk("re4_iaddr", iaddr, 32'h4);
      fill(32'h11111111);

      // redirect during FETCH
      imemaddr = 32'h10; #1;
      chk("m10_ihit", {31'b0, ihit}, 32'd0);
      tick();
      imemaddr = 32'h80;
      iwait = 1'b0; iload = 32'h10101010; #1;
      chk("rd_iaddr", iaddr, 32'h10);
      chk("rd_ihit", {31'b0, ihit}, 32'd0);
      tick();
      iwait = 1'b1; iload = '0; #1;
      chk("m80_ihit", {31'b0, ihit}, 32'd0);
      tick();
      chk("m80_iaddr", iaddr, 32'h80);
      fill(32'h80808080);
      chk("h80_load", imemload, 32'h80808080);
      imemaddr = 32'h10; #1;
      chk("h10_ihit", {31'b0, ihit}, 32'd1);
      chk("h10_load", imemload, 32'h10101010);

      // halt during FETCH
      imemaddr = 32'h20; #1;
      tick();
      imemREN = 1'b0;
      fill(32'h20202020);
      chk("halt_iREN", {31'b0, iREN}, 32'd0);
      chk("halt_ihit", {31'b0, ihit}, 32'd0);
      tick();
      chk("halt_idle_iREN", {31'b0, iREN}, 32'd0);
      imemREN = 1'b1; #1;
      chk("h20_load", imemload, 32'h20202020);

      // reset mid-FETCH
      imemaddr = 32'h8; #1;
      tick();
      chk("r_f_iREN", {31'b0, iREN}, 32'd1);
      nRST = 1'b0; #1;
      chk("r_iREN", {31'b0, iREN}, 32'd0);
      chk("r_iaddr", iaddr, 32'h0);
      tick();
      nRST = 1'b1;
      imemaddr = 32'h0; #1;
      chk("r_m0_ihit", {31'b0, ihit}, 32'd0);
      tick();
      chk("r_m0_iaddr", iaddr, 32'h0);
      fill(32'h2008000A);

      // idle with imemREN low: nothing happens
      imemREN = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("off_ihit", {31'b0, ihit}, 32'd0);
         chk("off_iREN", {31'b0, iREN}, 32'd0);
         tick();
      end
      imemREN = 1'b1; #1;
      chk("on_ihit", {31'b0, ihit}, 32'd1);
      chk("on_load", imemload, 32'h2008000A);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
